// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: loads a literal queue from memory, then polls BCP engines round-robin,
// deduplicating literals and flagging a conflict when a literal and its negation are both queued.
module uc_arbiter #(
  parameter int unsigned UCQ_SIZE   = 16,
  parameter int unsigned UC_LENGTH  = 1024,
  parameter int unsigned NUM_ENGINE = 4,
  localparam int unsigned LW        = $clog2(UC_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem2uca_valid,
  input  logic                  mem2uca_done,
  input  logic signed [LW-1:0]  mem2uca,
  input  logic                  eng2uca_valid,
  input  logic                  eng2uca_empty,
  input  logic signed [LW-1:0]  eng2uca,
  input  logic                  eng2uca_rd,
  output logic signed [LW-1:0]  uca2eng,
  output logic [NUM_ENGINE-1:0] engmask,
  output logic                  conflict
);

  localparam int unsigned PW = $clog2(UCQ_SIZE);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StLoad, StPoll} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic signed [LW-1:0]  r_queue [UCQ_SIZE];
  logic [UCQ_SIZE-1:0]   r_valid;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [NUM_ENGINE-1:0] r_engmask;
  logic                  r_conflict;

  logic                  w_push_req;
  logic signed [LW-1:0]  w_lit;
  logic signed [LW-1:0]  w_neg_lit;
  logic                  w_dup;
  logic                  w_neg;
  logic                  w_nonzero;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_space;
  logic                  w_push;
  logic                  w_conf_set;
  logic                  w_stall;
  logic                  w_rotate;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; POLL is left only by reset
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StLoad:  if (mem2uca_done) w_state_next = StPoll;
      StPoll:  w_state_next = StPoll;
      default: w_state_next = StLoad;
    endcase
  end

  // Output logic: source selection per state
  always_comb begin
    w_push_req = 1'b0;
    w_lit      = '0;
    unique case (r_state)
      StLoad: begin
        w_push_req = mem2uca_valid;
        w_lit      = mem2uca;
      end
      StPoll: begin
        w_push_req = !eng2uca_valid && !eng2uca_empty;
        w_lit      = eng2uca;
      end
      default: begin
        w_push_req = 1'b0;
        w_lit      = '0;
      end
    endcase
  end

  assign w_neg_lit = -w_lit;

  // Parallel match of the incoming literal and its negation against all live entries
  always_comb begin
    w_dup = 1'b0;
    w_neg = 1'b0;
    for (int i = 0; i < int'(UCQ_SIZE); i++) begin
      if (r_valid[i] && (r_queue[i] == w_lit))     w_dup = 1'b1;
      if (r_valid[i] && (r_queue[i] == w_neg_lit)) w_neg = 1'b1;
    end
  end

  assign w_nonzero  = (w_lit != '0);
  assign w_full     = (r_count == CW'(UCQ_SIZE));
  assign w_pop      = eng2uca_rd && (r_count != '0);
  assign w_space    = !w_full || w_pop;
  assign w_push     = w_push_req && w_nonzero && !w_dup && w_space;
  assign w_conf_set = w_push_req && w_nonzero && w_neg && !w_dup;
  assign w_stall    = w_push_req && w_nonzero && !w_dup && !w_space;
  assign w_rotate   = (r_state == StPoll) && !eng2uca_valid && !w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_engmask <= '0;
    end else if ((r_state == StLoad) && mem2uca_done) begin
      r_engmask <= NUM_ENGINE'(1);
    end else if (w_rotate) begin
      r_engmask <= {r_engmask[NUM_ENGINE-2:0], r_engmask[NUM_ENGINE-1]};
    end
  end

  // Push is written after pop so a same-slot push on a full queue keeps its valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_queue[r_tail] <= w_lit;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_conf_set) r_conflict <= 1'b1;
    end
  end

  assign uca2eng  = (r_count != '0) ? r_queue[r_head] : '0;
  assign engmask  = r_engmask;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_uc_arbiter.sv
// Scoreboard bench for uc_arbiter: a reference queue model predicts every broadcast literal,
// the engine select sequence and the conflict flag.
module tb_uc_arbiter;

  localparam int LW = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mem2uca_valid;
  logic                 mem2uca_done;
  logic signed [LW-1:0] mem2uca;
  logic                 eng2uca_valid;
  logic                 eng2uca_empty;
  logic signed [LW-1:0] eng2uca;
  logic                 eng2uca_rd;
  logic signed [LW-1:0] uca2eng;
  logic [3:0]           engmask;
  logic                 conflict;

  logic signed [LW-1:0] sb[$];
  logic                 exp_conf;
  logic [3:0]           exp_mask;
  int                   errors = 0;
  int                   checks = 0;

  uc_arbiter #(
    .UCQ_SIZE  (16),
    .UC_LENGTH (1024),
    .NUM_ENGINE(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem2uca_valid(mem2uca_valid),
    .mem2uca_done (mem2uca_done),
    .mem2uca      (mem2uca),
    .eng2uca_valid(eng2uca_valid),
    .eng2uca_empty(eng2uca_empty),
    .eng2uca      (eng2uca),
    .eng2uca_rd   (eng2uca_rd),
    .uca2eng      (uca2eng),
    .engmask      (engmask),
    .conflict     (conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rot(input logic [3:0] m);
    return {m[2:0], m[3]};
  endfunction

  // Reference push rule; returns 1 when the literal lands in the queue
  task automatic model_push(input logic signed [LW-1:0] lit, output bit pushed);
    bit dup = 0;
    bit neg = 0;
    logic signed [LW-1:0] nl;
    nl = -lit;
    pushed = 0;
    if (lit == 0) return;
    foreach (sb[i]) begin
      if (sb[i] == lit) dup = 1;
      if (sb[i] == nl)  neg = 1;
    end
    if (dup) return;
    if (neg) exp_conf = 1;
    if (sb.size() < 16) begin
      sb.push_back(lit);
      pushed = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_conf = 1'b0;
    exp_mask = 4'b0000;
  endtask

  task automatic mem_load(input logic signed [LW-1:0] lit);
    bit p;
    mem2uca_valid = 1'b1;
    mem2uca       = lit;
    model_push(lit, p);
    tick();
    mem2uca_valid = 1'b0;
  endtask

  // Engines stay empty while draining, so engmask rotates every cycle
  task automatic drain(input string tag);
    logic signed [LW-1:0] exp;
    eng2uca_valid = 1'b0;
    eng2uca_empty = 1'b1;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      checks++;
      if (uca2eng !== exp) begin
        errors++;
        $display("FAIL %s_read: uca2eng=%0d expected=%0d", tag, uca2eng, exp);
      end
      eng2uca_rd = 1'b1;
      tick();
      if (exp_mask != 4'b0000) exp_mask = rot(exp_mask);
    end
    eng2uca_rd = 1'b0;
    checks++;
    if (uca2eng !== '0) begin
      errors++;
      $display("FAIL %s_empty: uca2eng=%0d expected=0", tag, uca2eng);
    end
    checks++;
    if (conflict !== exp_conf) begin
      errors++;
      $display("FAIL %s_conflict: conflict=%0b expected=%0b", tag, conflict, exp_conf);
    end
    checks++;
    if (engmask !== exp_mask) begin
      errors++;
      $display("FAIL %s_mask: engmask=%b expected=%b", tag, engmask, exp_mask);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (engmask !== 4'b0000) begin
      errors++;
      $display("FAIL reset_engmask: engmask=%b expected=0000", engmask);
    end
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_conflict: conflict=%0b expected=0", conflict);
    end
    checks++;
    if (uca2eng !== '0) begin
      errors++;
      $display("FAIL reset_uca2eng: uca2eng=%0d expected=0", uca2eng);
    end
  endtask

  task automatic test_load();
    int vals[5] = '{10, 20, 30, 40, 50};
    foreach (vals[i]) begin
      mem_load(LW'(vals[i]));
      if (i == 0) begin
        checks++;
        if (uca2eng !== 10'sd10) begin
          errors++;
          $display("FAIL load_latency: uca2eng=%0d expected=10", uca2eng);
        end
      end
    end
    mem_load(10'sd0);
    mem_load(10'sd30);
    checks++;
    if (engmask !== 4'b0000) begin
      errors++;
      $display("FAIL load_engmask: engmask=%b expected=0000", engmask);
    end
    mem2uca_done = 1'b1;
    tick();
    exp_mask = 4'b0001;
    checks++;
    if (engmask !== exp_mask) begin
      errors++;
      $display("FAIL load_done_engmask: engmask=%b expected=%b", engmask, exp_mask);
    end
    checks++;
    if (sb.size() != 5 || uca2eng !== 10'sd10) begin
      errors++;
      $display("FAIL load_head: uca2eng=%0d size=%0d expected=10 size=5", uca2eng, sb.size());
    end
  endtask

  task automatic test_poll_conflict();
    int offers[4] = '{2, 4, 3, -2};
    bit p;
    eng2uca_valid = 1'b0;
    foreach (offers[i]) begin
      checks++;
      if (engmask !== exp_mask) begin
        errors++;
        $display("FAIL poll_mask%0d: engmask=%b expected=%b", i, engmask, exp_mask);
      end
      eng2uca_empty = 1'b0;
      eng2uca       = LW'(offers[i]);
      model_push(LW'(offers[i]), p);
      tick();
      exp_mask = rot(exp_mask);
    end
    eng2uca_empty = 1'b1;
    checks++;
    if (conflict !== 1'b1 || exp_conf !== 1'b1) begin
      errors++;
      $display("FAIL poll_conflict: conflict=%0b expected=1", conflict);
    end
    checks++;
    if (sb.size() != 9 || engmask !== 4'b0001) begin
      errors++;
      $display("FAIL poll_wrap: engmask=%b size=%0d expected=0001 size=9", engmask, sb.size());
    end
  endtask

  task automatic test_reads();
    drain("reads");
    eng2uca_rd = 1'b1;
    tick();
    exp_mask = rot(exp_mask);
    eng2uca_rd = 1'b0;
    checks++;
    if (uca2eng !== '0 || conflict !== 1'b1) begin
      errors++;
      $display("FAIL rd_on_empty: uca2eng=%0d conflict=%0b expected=0 1", uca2eng, conflict);
    end
  endtask

  task automatic test_empty_dup_busy();
    bit p;
    eng2uca_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_mask = rot(exp_mask);
      checks++;
      if (engmask !== exp_mask) begin
        errors++;
        $display("FAIL empty_rotate%0d: engmask=%b expected=%b", i, engmask, exp_mask);
      end
    end
    eng2uca_empty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      eng2uca = 10'sd20;
      model_push(10'sd20, p);
      tick();
      exp_mask = rot(exp_mask);
    end
    eng2uca_valid = 1'b1;
    eng2uca       = 10'sd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (engmask !== exp_mask) begin
        errors++;
        $display("FAIL busy_hold%0d: engmask=%b expected=%b", i, engmask, exp_mask);
      end
    end
    eng2uca_valid = 1'b0;
    drain("dup");
  endtask

  task automatic test_full_wrap();
    bit p;
    do_reset();
    mem2uca_done  = 1'b0;
    eng2uca_empty = 1'b1;
    for (int i = 0; i < 17; i++) mem_load(LW'(100 + i));
    mem2uca_done = 1'b1;
    tick();
    exp_mask = 4'b0001;
    eng2uca_empty = 1'b0;
    eng2uca       = 10'sd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (engmask !== exp_mask) begin
        errors++;
        $display("FAIL full_stall%0d: engmask=%b expected=%b", i, engmask, exp_mask);
      end
    end
    checks++;
    if (uca2eng !== 10'sd100) begin
      errors++;
      $display("FAIL full_head: uca2eng=%0d expected=100", uca2eng);
    end
    eng2uca_rd = 1'b1;
    void'(sb.pop_front());
    model_push(10'sd7, p);
    tick();
    exp_mask = rot(exp_mask);
    eng2uca_rd = 1'b0;
    checks++;
    if (engmask !== exp_mask || !p) begin
      errors++;
      $display("FAIL full_accept: engmask=%b expected=%b", engmask, exp_mask);
    end
    eng2uca = 10'sd0;
    model_push(10'sd0, p);
    tick();
    exp_mask = rot(exp_mask);
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    mem2uca_done  = 1'b0;
    eng2uca_empty = 1'b1;
    do_reset();
    mem_load(10'sd5);
    mem_load(-10'sd5);
    checks++;
    if (uca2eng !== 10'sd5 || conflict !== 1'b1) begin
      errors++;
      $display("FAIL mem_conflict: uca2eng=%0d conflict=%0b expected=5 1", uca2eng, conflict);
    end
    do_reset();
    checks++;
    if (uca2eng !== '0 || conflict !== 1'b0 || engmask !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: uca2eng=%0d conflict=%0b engmask=%b expected=0 0 0000",
               uca2eng, conflict, engmask);
    end
  endtask

  initial begin
    rst           = 1'b1;
    mem2uca_valid = 1'b0;
    mem2uca_done  = 1'b0;
    mem2uca       = '0;
    eng2uca_valid = 1'b0;
    eng2uca_empty = 1'b1;
    eng2uca       = '0;
    eng2uca_rd    = 1'b0;
    exp_conf      = 1'b0;
    exp_mask      = 4'b0000;
    test_reset();
    test_load();
    test_poll_conflict();
    test_reads();
    test_empty_dup_busy();
    test_full_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
